alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- ID/EX pipeline stage directly upstream of the 64-bit ALU.
- Accepts decoded RV64I fields from decode and resolves rs1/rs2 operands through a two-source forwarding network.
- Generates the 4-bit ALU control code and registers ALU operands plus side-band for the EX stage.
- Owns the valid/ready handshake, flush, and one-cycle load-use bubble insertion.

Parameters:
XLEN, 64, datapath width of operands and immediates
RA_W, 5, register-index width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage accepts the instruction this cycle
opcode  in  7  instruction[6:0]
funct3  in  3  instruction[14:12]
funct7_5  in  1  instruction[30]
rs1_idx, rs2_idx, rd_idx  in  RA_W each  register indices
rs1_data, rs2_data  in  XLEN each  register-file read data
imm  in  XLEN  sign-extended immediate
fwd0_en, fwd0_rd, fwd0_data  in  1/RA_W/XLEN  ALU-result bypass from the instruction one ahead (priority)
fwd1_en, fwd1_rd, fwd1_data  in  1/RA_W/XLEN  writeback bypass, including load data
flush  in  1  kill the held instruction and the incoming one
out_valid  out  1  registered operands valid for the ALU
out_ready  in  1  EX stage consumes this cycle
alu_a, alu_b  out  XLEN  registered ALU operands
alu_control  out  4  0 AND, 1 OR, 2 ADD, 3 SLL, 4 SRL, 5 SRA, 6 SUB, 7 SLTU, 8 SLT, 9 XOR
out_rd  out  RA_W  destination index
out_wr_en  out  1  instruction writes rd (rd != 0)
out_is_load, out_is_store, out_illegal  out  1 each  class flags
out_store_data  out  XLEN  forwarded rs2 for stores

Behaviour:
- Reset (rst_n low, asynchronous): out_valid = 0 and every registered output = 0. in_ready follows the combinational rule below.
- Decode:
  - OP (0110011): funct3 000 gives ADD, or SUB when funct7_5 = 1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when funct7_5 = 1; 110 OR; 111 AND.
  - OP-IMM (0010011): same mapping, except funct3 000 is always ADD.
  - LOAD (0000011) and STORE (0100011): ADD.
  - Any other opcode: ADD, out_illegal = 1, out_wr_en = 0.
- Operands:
  - alu_a = fwd(rs1).
  - alu_b = fwd(rs2) for OP; imm for OP-IMM, LOAD and STORE.
  - For OP-IMM shifts, alu_b = zero-extended imm[5:0].
  - out_store_data = fwd(rs2).
- fwd(r):
  - index 0 resolves to 0;
  - otherwise fwd0_data if fwd0_en and fwd0_rd == r;
  - else fwd1_data if fwd1_en and fwd1_rd == r;
  - else the register-file data.
  - Resolution is at capture; held values never re-forward.
- uses_rs1 is set for all four opcode classes. uses_rs2 is set for OP and STORE only.
- out_wr_en = (OP | OP-IMM | LOAD) & rd_idx != 0.
- hazard = out_valid & out_is_load & out_rd != 0 & in_valid & ((uses_rs1 & rs1_idx == out_rd) | (uses_rs2 & rs2_idx == out_rd)).
- adv = !out_valid | out_ready.
- in_ready = adv & !hazard & !flush | flush (flush drops the incoming instruction).
- Each edge, in priority order:
  1. flush: out_valid <= 0.
  2. else if adv & in_valid & !hazard: capture, out_valid <= 1.
  3. else if adv: out_valid <= 0 (bubble).
  4. else hold; all outputs stable while out_valid & !out_ready.
- Load-use costs exactly one bubble: the load leaves on out_ready, the dependent instruction is captured next cycle, and the load data arrives via fwd1.
- Back-to-back issue at full rate when there is no hazard and out_ready = 1. Latency is one cycle from acceptance to out_valid.
- Reset mid-stall clears out_valid immediately, with no residual capture.

Test Plan:
- Reset: rst_n = 0 while in_valid = 1 -> out_valid = 0, alu_a = alu_b = 0, alu_control = 0; after release, first OP accepted next edge.
- OP SUB: funct3 = 000, funct7_5 = 1, rs1_data = -13, rs2_data = 3 -> one cycle later alu_control = 6, alu_a = -13, alu_b = 3; OP-IMM SRAI imm = 0x403 -> alu_control = 5, alu_b = 3.
- Forwarding: rs1_idx = 5, fwd0 and fwd1 both hit rd 5 with 0xAA and 0xBB -> alu_a = 0xAA. Rs1_idx = 0 with fwd0_rd = 0 -> alu_a = 0.
- Load-use: LOAD rd = 7 held, next instruction OP with rs2 = 7 -> in_ready = 0 for one cycle, out_valid = 0 bubble, then capture with alu_b = fwd1_data.
- Backpressure: out_ready = 0 for 3 cycles with in_valid = 1 -> outputs frozen, in_ready = 0; on release, the held instruction retires and the new one is captured the same edge.
- Flush: flush = 1 while holding an instruction and in_valid = 1 -> out_valid = 0 next edge, in_ready = 1, incoming dropped; opcode 1101111 -> out_illegal = 1, out_wr_en = 0.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - decode-to-ALU issue stage handshake and operand bus
interface alu_issue_stage_if #(
    parameter int XLEN = 64,
    parameter int RA_W = 5
);
    // decode side
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic [RA_W-1:0] rs1_idx;
    logic [RA_W-1:0] rs2_idx;
    logic [RA_W-1:0] rd_idx;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;

    // bypass sources
    logic            fwd0_en;
    logic [RA_W-1:0] fwd0_rd;
    logic [XLEN-1:0] fwd0_data;
    logic            fwd1_en;
    logic [RA_W-1:0] fwd1_rd;
    logic [XLEN-1:0] fwd1_data;

    logic            flush;

    // EX side
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_control;
    logic [RA_W-1:0] out_rd;
    logic            out_wr_en;
    logic            out_is_load;
    logic            out_is_store;
    logic            out_illegal;
    logic [XLEN-1:0] out_store_data;

    modport master (
        output in_valid, opcode, funct3, funct7_5, rs1_idx, rs2_idx, rd_idx,
               rs1_data, rs2_data, imm,
               fwd0_en, fwd0_rd, fwd0_data, fwd1_en, fwd1_rd, fwd1_data,
               flush, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_control, out_rd,
               out_wr_en, out_is_load, out_is_store, out_illegal, out_store_data
    );

    modport slave (
        input  in_valid, opcode, funct3, funct7_5, rs1_idx, rs2_idx, rd_idx,
               rs1_data, rs2_data, imm,
               fwd0_en, fwd0_rd, fwd0_data, fwd1_en, fwd1_rd, fwd1_data,
               flush, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_control, out_rd,
               out_wr_en, out_is_load, out_is_store, out_illegal, out_store_data
    );
endinterface

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ID/EX stage: decode, operand forwarding, load-use bubble
module alu_issue_stage #(
    parameter int XLEN = 64,
    parameter int RA_W = 5
) (
    input logic          clk,
    input logic          rst_n,
    alu_issue_stage_if.slave bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [3:0] CTL_AND  = 4'd0;
    localparam logic [3:0] CTL_OR   = 4'd1;
    localparam logic [3:0] CTL_ADD  = 4'd2;
    localparam logic [3:0] CTL_SLL  = 4'd3;
    localparam logic [3:0] CTL_SRL  = 4'd4;
    localparam logic [3:0] CTL_SRA  = 4'd5;
    localparam logic [3:0] CTL_SUB  = 4'd6;
    localparam logic [3:0] CTL_SLTU = 4'd7;
    localparam logic [3:0] CTL_SLT  = 4'd8;
    localparam logic [3:0] CTL_XOR  = 4'd9;

    // registered stage state
    logic            out_valid_q,      out_valid_d;
    logic [XLEN-1:0] alu_a_q,          alu_a_d;
    logic [XLEN-1:0] alu_b_q,          alu_b_d;
    logic [3:0]      alu_control_q,    alu_control_d;
    logic [RA_W-1:0] out_rd_q,         out_rd_d;
    logic            out_wr_en_q,      out_wr_en_d;
    logic            out_is_load_q,    out_is_load_d;
    logic            out_is_store_q,   out_is_store_d;
    logic            out_illegal_q,    out_illegal_d;
    logic [XLEN-1:0] out_store_data_q, out_store_data_d;

    // decode results for the incoming instruction
    logic            is_op, is_op_imm, is_load, is_store, is_legal;
    logic            uses_rs1, uses_rs2;
    logic            is_shift;
    logic [3:0]      dec_control;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic [XLEN-1:0] dec_b;
    logic            hazard, adv;

    // classify opcode and derive the ALU control code
    always_comb begin
        is_op     = (bus.opcode == OPC_OP);
        is_op_imm = (bus.opcode == OPC_OP_IMM);
        is_load   = (bus.opcode == OPC_LOAD);
        is_store  = (bus.opcode == OPC_STORE);
        is_legal  = is_op | is_op_imm | is_load | is_store;
        uses_rs1  = is_legal;
        uses_rs2  = is_op | is_store;
        is_shift  = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b101);
        dec_control = CTL_ADD;
        if (is_op || is_op_imm) begin
            case (bus.funct3)
                3'b000:  dec_control = (is_op && bus.funct7_5) ? CTL_SUB : CTL_ADD;
                3'b001:  dec_control = CTL_SLL;
                3'b010:  dec_control = CTL_SLT;
                3'b011:  dec_control = CTL_SLTU;
                3'b100:  dec_control = CTL_XOR;
                3'b101:  dec_control = bus.funct7_5 ? CTL_SRA : CTL_SRL;
                3'b110:  dec_control = CTL_OR;
                default: dec_control = CTL_AND;
            endcase
        end
    end

    // two-source bypass: x0 is hardwired, the younger ALU result wins over writeback
    always_comb begin
        rs1_fwd = bus.rs1_data;
        if (bus.rs1_idx == '0) begin
            rs1_fwd = '0;
        end else if (bus.fwd0_en && bus.fwd0_rd == bus.rs1_idx) begin
            rs1_fwd = bus.fwd0_data;
        end else if (bus.fwd1_en && bus.fwd1_rd == bus.rs1_idx) begin
            rs1_fwd = bus.fwd1_data;
        end

        rs2_fwd = bus.rs2_data;
        if (bus.rs2_idx == '0) begin
            rs2_fwd = '0;
        end else if (bus.fwd0_en && bus.fwd0_rd == bus.rs2_idx) begin
            rs2_fwd = bus.fwd0_data;
        end else if (bus.fwd1_en && bus.fwd1_rd == bus.rs2_idx) begin
            rs2_fwd = bus.fwd1_data;
        end
    end

    // second operand: register for OP, shift amount for immediate shifts, else immediate
    always_comb begin
        dec_b = bus.imm;
        if (is_op) begin
            dec_b = rs2_fwd;
        end else if (is_op_imm && is_shift) begin
            dec_b = {{(XLEN-6){1'b0}}, bus.imm[5:0]};
        end
    end

    // load-use detection against the held instruction, and stage advance condition
    always_comb begin
        hazard = out_valid_q && out_is_load_q && (out_rd_q != '0) && bus.in_valid &&
                 ((uses_rs1 && bus.rs1_idx == out_rd_q) ||
                  (uses_rs2 && bus.rs2_idx == out_rd_q));
        adv    = !out_valid_q || bus.out_ready;
    end

    // next-state: flush beats capture, capture beats bubble, otherwise hold
    always_comb begin
        out_valid_d      = out_valid_q;
        alu_a_d          = alu_a_q;
        alu_b_d          = alu_b_q;
        alu_control_d    = alu_control_q;
        out_rd_d         = out_rd_q;
        out_wr_en_d      = out_wr_en_q;
        out_is_load_d    = out_is_load_q;
        out_is_store_d   = out_is_store_q;
        out_illegal_d    = out_illegal_q;
        out_store_data_d = out_store_data_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (adv && bus.in_valid && !hazard) begin
            out_valid_d      = 1'b1;
            alu_a_d          = rs1_fwd;
            alu_b_d          = dec_b;
            alu_control_d    = dec_control;
            out_rd_d         = bus.rd_idx;
            out_wr_en_d      = (is_op || is_op_imm || is_load) && (bus.rd_idx != '0);
            out_is_load_d    = is_load;
            out_is_store_d   = is_store;
            out_illegal_d    = !is_legal;
            out_store_data_d = rs2_fwd;
        end else if (adv) begin
            out_valid_d = 1'b0;
        end
    end

    // stage registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q      <= 1'b0;
            alu_a_q          <= '0;
            alu_b_q          <= '0;
            alu_control_q    <= '0;
            out_rd_q         <= '0;
            out_wr_en_q      <= 1'b0;
            out_is_load_q    <= 1'b0;
            out_is_store_q   <= 1'b0;
            out_illegal_q    <= 1'b0;
            out_store_data_q <= '0;
        end else begin
            out_valid_q      <= out_valid_d;
            alu_a_q          <= alu_a_d;
            alu_b_q          <= alu_b_d;
            alu_control_q    <= alu_control_d;
            out_rd_q         <= out_rd_d;
            out_wr_en_q      <= out_wr_en_d;
            out_is_load_q    <= out_is_load_d;
            out_is_store_q   <= out_is_store_d;
            out_illegal_q    <= out_illegal_d;
            out_store_data_q <= out_store_data_d;
        end
    end

    // flush always accepts so the incoming instruction is dropped, not stalled
    assign bus.in_ready       = (adv && !hazard && !bus.flush) || bus.flush;
    assign bus.out_valid      = out_valid_q;
    assign bus.alu_a          = alu_a_q;
    assign bus.alu_b          = alu_b_q;
    assign bus.alu_control    = alu_control_q;
    assign bus.out_rd         = out_rd_q;
    assign bus.out_wr_en      = out_wr_en_q;
    assign bus.out_is_load    = out_is_load_q;
    assign bus.out_is_store   = out_is_store_q;
    assign bus.out_illegal    = out_illegal_q;
    assign bus.out_store_data = out_store_data_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed vector bench for alu_issue_stage
module tb_alu_issue_stage;
    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [63:0] NEG13 = 64'hFFFF_FFFF_FFFF_FFF3;
    localparam logic [63:0] ALL1  = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rs1, rs2, rd;
        logic [63:0] d1, d2, imm;
        logic        f0en;
        logic [4:0]  f0rd;
        logic [63:0] f0d;
        logic        f1en;
        logic [4:0]  f1rd;
        logic [63:0] f1d;
        logic [63:0] ea, eb;
        logic [3:0]  ectl;
        logic        ewr, eld, est, eill;
        logic [63:0] esd;
        logic        chk_b;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[18];

    alu_issue_stage_if #(.XLEN(64), .RA_W(5)) bus ();

    alu_issue_stage #(.XLEN(64), .RA_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(
        input logic [6:0] opcode, input logic [2:0] f3, input logic f7,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
        input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] imm,
        input logic f0en, input logic [4:0] f0rd, input logic [63:0] f0d,
        input logic f1en, input logic [4:0] f1rd, input logic [63:0] f1d,
        input logic [63:0] ea, input logic [63:0] eb, input logic [3:0] ectl,
        input logic ewr, input logic eld, input logic est, input logic eill,
        input logic [63:0] esd, input logic chk_b);
        vec_t v;
        v.opcode = opcode; v.f3 = f3; v.f7 = f7;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.d1 = d1; v.d2 = d2; v.imm = imm;
        v.f0en = f0en; v.f0rd = f0rd; v.f0d = f0d;
        v.f1en = f1en; v.f1rd = f1rd; v.f1d = f1d;
        v.ea = ea; v.eb = eb; v.ectl = ectl;
        v.ewr = ewr; v.eld = eld; v.est = est; v.eill = eill;
        v.esd = esd; v.chk_b = chk_b;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.opcode    = v.opcode;
        bus.funct3    = v.f3;
        bus.funct7_5  = v.f7;
        bus.rs1_idx   = v.rs1;
        bus.rs2_idx   = v.rs2;
        bus.rd_idx    = v.rd;
        bus.rs1_data  = v.d1;
        bus.rs2_data  = v.d2;
        bus.imm       = v.imm;
        bus.fwd0_en   = v.f0en;
        bus.fwd0_rd   = v.f0rd;
        bus.fwd0_data = v.f0d;
        bus.fwd1_en   = v.f1en;
        bus.fwd1_rd   = v.f1rd;
        bus.fwd1_data = v.f1d;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        chk({tag, "_valid"},   {63'd0, bus.out_valid},    64'd1);
        chk({tag, "_alu_a"},   bus.alu_a,                 v.ea);
        if (v.chk_b) chk({tag, "_alu_b"}, bus.alu_b,      v.eb);
        chk({tag, "_ctl"},     {60'd0, bus.alu_control},  {60'd0, v.ectl});
        chk({tag, "_rd"},      {59'd0, bus.out_rd},       {59'd0, v.rd});
        chk({tag, "_wr_en"},   {63'd0, bus.out_wr_en},    {63'd0, v.ewr});
        chk({tag, "_load"},    {63'd0, bus.out_is_load},  {63'd0, v.eld});
        chk({tag, "_store"},   {63'd0, bus.out_is_store}, {63'd0, v.est});
        chk({tag, "_illegal"}, {63'd0, bus.out_illegal},  {63'd0, v.eill});
        chk({tag, "_sdata"},   bus.out_store_data,        v.esd);
    endtask

    initial begin
        vec_t lv, dv, ov, sv;

        //            opc f3 f7 rs1 rs2 rd  d1        d2        imm                      f0en rd  data      f1en rd data      ea        eb     ctl wr ld st il sd        chkb
        vecs[0]  = mk(OP,  0, 1,  1,  2,  3, NEG13,    64'd3,    64'd0,                   0,  0, 64'd0,    0,  0, 64'd0,    NEG13,    64'd3,   6, 1, 0, 0, 0, 64'd3,    1);
        vecs[1]  = mk(OPI, 5, 1,  4,  6,  5, 64'h80,   64'h66,   64'h403,                 0,  0, 64'd0,    0,  0, 64'd0,    64'h80,   64'd3,   5, 1, 0, 0, 0, 64'h66,   1);
        vecs[2]  = mk(OP,  0, 0,  5,  6,  7, 64'h11,   64'h22,   64'd0,                   1,  5, 64'hAA,   1,  5, 64'hBB,   64'hAA,   64'h22,  2, 1, 0, 0, 0, 64'h22,   1);
        vecs[3]  = mk(OP,  4, 0,  8,  9, 10, 64'h5,    64'h99,   64'd0,                   1,  3, 64'h1,    1,  9, 64'hBB,   64'h5,    64'hBB,  9, 1, 0, 0, 0, 64'hBB,   1);
        vecs[4]  = mk(OPI, 0, 1,  0,  0,  0, 64'h1234, 64'h5678, ALL1,                    1,  0, 64'hAA,   1,  0, 64'hBB,   64'd0,    ALL1,    2, 0, 0, 0, 0, 64'd0,    1);
        vecs[5]  = mk(LD,  3, 0, 12,  0, 11, 64'h1000, 64'h9,    64'd16,                  0,  0, 64'd0,    0,  0, 64'd0,    64'h1000, 64'd16,  2, 1, 1, 0, 0, 64'd0,    1);
        vecs[6]  = mk(ST,  3, 0, 13, 14, 15, 64'h2000, 64'hDEAD, 64'd8,                   0,  0, 64'd0,    0,  0, 64'd0,    64'h2000, 64'd8,   2, 0, 0, 1, 0, 64'hDEAD, 1);
        vecs[7]  = mk(OP,  1, 0,  1,  2,  3, 64'd1,    64'd4,    64'd0,                   0,  0, 64'd0,    0,  0, 64'd0,    64'd1,    64'd4,   3, 1, 0, 0, 0, 64'd4,    1);
        vecs[8]  = mk(OP,  5, 0,  1,  2,  3, 64'd1,    64'd4,    64'd0,                   0,  0, 64'd0,    0,  0, 64'd0,    64'd1,    64'd4,   4, 1, 0, 0, 0, 64'd4,    1);
        vecs[9]  = mk(OP,  3, 0,  1,  2,  3, 64'd1,    64'd4,    64'd0,                   0,  0, 64'd0,    0,  0, 64'd0,    64'd1,    64'd4,   7, 1, 0, 0, 0, 64'd4,    1);
        vecs[10] = mk(OP,  2, 0,  1,  2,  3, 64'd1,    64'd4,    64'd0,                   0,  0, 64'd0,    0,  0, 64'd0,    64'd1,    64'd4,   8, 1, 0, 0, 0, 64'd4,    1);
        vecs[11] = mk(OP,  6, 0,  1,  2,  3, 64'd1,    64'd4,    64'd0,                   0,  0, 64'd0,    0,  0, 64'd0,    64'd1,    64'd4,   1, 1, 0, 0, 0, 64'd4,    1);
        vecs[12] = mk(OP,  7, 0,  1,  2,  3, 64'd1,    64'd4,    64'd0,                   0,  0, 64'd0,    0,  0, 64'd0,    64'd1,    64'd4,   0, 1, 0, 0, 0, 64'd4,    1);
        vecs[13] = mk(OPI, 1, 0,  1,  2,  3, 64'd1,    64'd4,    64'hFFFF_FFFF_FFFF_FFC5, 0,  0, 64'd0,    0,  0, 64'd0,    64'd1,    64'd5,   3, 1, 0, 0, 0, 64'd4,    1);
        vecs[14] = mk(OPI, 2, 0,  1,  2,  3, 64'd1,    64'd4,    64'h7FF,                 0,  0, 64'd0,    0,  0, 64'd0,    64'd1,    64'h7FF, 8, 1, 0, 0, 0, 64'd4,    1);
        vecs[15] = mk(JAL, 0, 0,  2,  0,  1, 64'h77,   64'd0,    64'h100,                 0,  0, 64'd0,    0,  0, 64'd0,    64'h77,   64'd0,   2, 0, 0, 0, 1, 64'd0,    0);
        vecs[16] = mk(OP,  0, 0, 17, 18, 19, 64'd1,    64'd2,    64'd0,                   1, 18, 64'h30,   1, 17, 64'h40,   64'h40,   64'h30,  2, 1, 0, 0, 0, 64'h30,   1);
        vecs[17] = mk(OP,  0, 0, 17, 18, 19, 64'd1,    64'd2,    64'd0,                   0, 17, 64'hAA,   0, 18, 64'hBB,   64'd1,    64'd2,   2, 1, 0, 0, 0, 64'd2,    1);

        // reset held while decode presents an instruction
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        drive(vecs[0]);
        step();
        step();
        chk("rst_out_valid", {63'd0, bus.out_valid},     64'd0);
        chk("rst_alu_a",     bus.alu_a,                  64'd0);
        chk("rst_alu_b",     bus.alu_b,                  64'd0);
        chk("rst_ctl",       {60'd0, bus.alu_control},   64'd0);
        chk("rst_in_ready",  {63'd0, bus.in_ready},      64'd1);
        rst_n = 1'b1;
        step();
        check_vec("first_after_rst", vecs[0]);

        // table at full rate, out_ready high
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i]);
            bus.in_valid = 1'b1;
            #1;
            chk($sformatf("v%0d_in_ready", i), {63'd0, bus.in_ready}, 64'd1);
            step();
            check_vec($sformatf("v%0d", i), vecs[i]);
        end

        // load-use: one bubble, dependent captures with writeback data
        lv = mk(LD, 3, 0, 1, 0, 7, 64'h500, 64'd0, 64'd8, 0, 0, 64'd0, 0, 0, 64'd0,
                64'h500, 64'd8, 2, 1, 1, 0, 0, 64'd0, 1);
        drive(lv);
        step();
        check_vec("lu_load", lv);
        dv = mk(OP, 0, 0, 1, 7, 8, 64'h10, 64'hBAD, 64'd0, 0, 0, 64'd0, 1, 7, 64'hCAFE,
                64'h10, 64'h1234_5678, 2, 1, 0, 0, 0, 64'h1234_5678, 1);
        drive(dv);
        #1;
        chk("lu_in_ready_stall", {63'd0, bus.in_ready}, 64'd0);
        step();
        chk("lu_bubble_valid", {63'd0, bus.out_valid}, 64'd0);
        bus.fwd1_data = 64'h1234_5678;
        #1;
        chk("lu_in_ready_after", {63'd0, bus.in_ready}, 64'd1);
        step();
        check_vec("lu_dep", dv);

        // backpressure: three stalled cycles, then retire and capture on one edge
        ov = mk(OP, 6, 0, 20, 21, 22, 64'h0F, 64'hF0, 64'd0, 0, 0, 64'd0, 0, 0, 64'd0,
                64'h0F, 64'hF0, 1, 1, 0, 0, 0, 64'hF0, 1);
        drive(ov);
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", c), {63'd0, bus.in_ready}, 64'd0);
            step();
            check_vec($sformatf("bp%0d_hold", c), dv);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {63'd0, bus.in_ready}, 64'd1);
        step();
        check_vec("bp_new", ov);

        // flush while holding and while decode presents an instruction
        bus.out_ready = 1'b0;
        drive(vecs[0]);
        bus.flush = 1'b1;
        #1;
        chk("fl_in_ready", {63'd0, bus.in_ready}, 64'd1);
        step();
        chk("fl_out_valid", {63'd0, bus.out_valid}, 64'd0);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        step();
        chk("fl_dropped", {63'd0, bus.out_valid}, 64'd0);

        // reset in the middle of a stall
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        sv = vecs[2];
        drive(sv);
        step();
        check_vec("ms_cap", sv);
        bus.out_ready = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ms_valid_async", {63'd0, bus.out_valid}, 64'd0);
        chk("ms_alu_a_async", bus.alu_a, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        step();
        chk("ms_no_residual", {63'd0, bus.out_valid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
